branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

- Resolves branches in the EX stage (stage 3) and checks them against the fetch-stage prediction.
- Carries each fetched instruction's PC and its predicted taken/target through the IF/ID and ID/EX registers.
- Computes the actual branch outcome from EX operands and drives the feedback bundle the branch predictor consumes (`is_branchInst_3`, `taken_3`, `prev_taken_3`, `target_3`, `instructionPC_3`).
- Produces a redirect PC, flushes the younger in-flight predictions on mispredict, and keeps saturating branch/mispredict counters.

## Interface
Parameters:
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  – the block's single clock.
- `rst`  in  1  – synchronous, active-high reset.
- `memory_stall`  in  1  – global pipeline stall; all state holds.
- `fetch_valid_1`  in  1  – stage-1 instruction is valid.
- `instructionPC_1`  in  32  – PC of the stage-1 instruction.
- `pred_taken_1`  in  1  – prediction from the branch predictor (its `taken` output).
- `pred_target_1`  in  32  – predicted next PC from the branch predictor (its `branchPC` output).
- `br_type_3`  in  3  – branch type: 0 = none, 1 = BEQ, 2 = BNE, 3 = JAL, 4 = JALR; 5–7 are treated as none.
- `rs1_3`, `rs2_3`  in  32 each  – forwarded EX operands.
- `imm_3`  in  32  – sign-extended immediate.
- `is_branchInst_3`  out  1  – stage 3 holds a valid control-transfer instruction.
- `taken_3`  out  1  – actual outcome.
- `prev_taken_3`  out  1  – predicted outcome carried to stage 3.
- `target_3`  out  32  – actual target.
- `instructionPC_3`  out  32  – PC of the stage-3 instruction.
- `mispredict_3`  out  1  – redirect required.
- `redirect_pc_3`  out  32  – correct next PC.
- `branch_cnt`  out  `CNT_W`  – resolved branches.
- `mispred_cnt`  out  `CNT_W`  – mispredictions.

## Operation
Pipeline registers:
- Stage-2 register (IF/ID) holds {valid, PC, pred_taken, pred_target}, loaded from the stage-1 inputs.
- Stage-3 register (ID/EX) holds the same fields, loaded from stage 2.
- `valid_3` is the valid bit of the stage-3 register.

Resolution (combinational from the stage-3 register and the `_3` inputs):
- `br` = `valid_3` and `br_type_3` in 1..4.
- Actual outcome:
  - BEQ: `taken` = (`rs1_3` == `rs2_3`).
  - BNE: `taken` = (`rs1_3` != `rs2_3`).
  - JAL and JALR: `taken` = 1.
- Target:
  - BEQ, BNE, JAL: PC_3 + `imm_3`.
  - JALR: (`rs1_3` + `imm_3`) with bit 0 cleared.
  - Additions are 32-bit and wrap; overflow is ignored.
- `next_pc` = `taken` ? target : PC_3 + 4.
- `mispredict_3` asserts in either of two cases:
  - `br` and (pred_taken != `taken`, or (`taken` and pred_target != target)).
  - `valid_3`, not `br`, and pred_taken = 1 (predicted taken on a non-branch).
- `redirect_pc_3` = `next_pc` whenever `valid_3` is set, else 0.
- `is_branchInst_3` = `br`; `taken_3` = `br` and `taken`; `prev_taken_3` = `valid_3` and pred_taken.
- `target_3` = target when `br`, else 0; `instructionPC_3` = PC_3.

Flush, on a clock edge where `mispredict_3` is set and `memory_stall` is low:
- Stage-3 valid is loaded with 0.
- Stage-2 valid is loaded with 0; the stage-1 instruction present at that edge is discarded.
- PC and prediction fields still load, but are don't-care.

Counters, on a clock edge with `memory_stall` low:
- `branch_cnt` increments when `br` is set.
- `mispred_cnt` increments when `mispredict_3` is set.
- Both saturate at all-ones.

## Timing
- Reset (`rst` high at the clock edge): all valid bits, PCs, predictions and counters go to 0, so every output is 0 the cycle after reset. Reset overrides stall and flush.
- Stage-1 inputs reach stage 3 after two non-stalled edges.
- Resolution outputs are combinational; they are valid the same cycle the `_3` inputs are valid.
- Stall: while `memory_stall` is high, all registers and counters hold.
  - `mispredict_3` and `redirect_pc_3` stay asserted throughout the stall.
  - Counters and the flush take effect exactly once, on the first edge with the stall low.
- A mispredict is raised by at most one instruction in any cycle. The instruction that enters stage 3 after a flush is a bubble (`valid_3` = 0), so two mispredicts can never occur back to back.
- A flush with `fetch_valid_1` = 0 has the same effect as with it set.
- Reset asserted during a stall or a flush wins.

## Test plan
- **Reset:** hold `rst` for 2 cycles. Required: all outputs 0, both counters 0.
- **Correct not-taken BEQ:**
  - Stimulus: PC 0x40, pred_taken 0, pred_target 0x44, then after 2 edges `br_type_3`=1, rs1=5, rs2=6.
  - Required: `mispredict_3`=0, `taken_3`=0, `redirect_pc_3`=0x44, `branch_cnt`=1 after the edge.
- **Taken BNE predicted not-taken:**
  - Stimulus: PC 0x80, imm 0x20, rs1=1, rs2=2, pred_taken 0.
  - Required: `mispredict_3`=1, `target_3`=0xA0, `redirect_pc_3`=0xA0.
  - Next cycle: `valid_3`=0 and the stage-2 entry is gone; `mispred_cnt`=1.
- **JALR wrong target:**
  - Stimulus: rs1=0x101, imm=0x10, pred_taken 1, pred_target 0x110.
  - Required: `target_3`=0x110, `mispredict_3`=0.
  - Repeat with pred_target 0x114: required `mispredict_3`=1.
- **Stall during mispredict:**
  - Stimulus: hold `memory_stall` high for 3 cycles while a mispredict sits in stage 3.
  - Required: outputs stable for all 3 cycles, `mispred_cnt` increments exactly once, and the flush happens on the release edge.
- **Non-branch predicted taken, plus saturation:**
  - Stimulus: PC 0x10, `br_type_3`=0, pred_taken 1.
  - Required: `mispredict_3`=1, `redirect_pc_3`=0x14.
  - Also: with `CNT_W`=2, after 5 mispredicts `mispred_cnt`=3.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: carries fetch predictions through IF/ID and ID/EX, resolves the
// branch combinationally in stage 3, flushes younger slots on mispredict; memory_stall freezes all state.
module branch_resolve_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memory_stall,
    input  logic             fetch_valid_1,
    input  logic [31:0]      instructionPC_1,
    input  logic             pred_taken_1,
    input  logic [31:0]      pred_target_1,
    input  logic [2:0]       br_type_3,
    input  logic [31:0]      rs1_3,
    input  logic [31:0]      rs2_3,
    input  logic [31:0]      imm_3,
    output logic             is_branchInst_3,
    output logic             taken_3,
    output logic             prev_taken_3,
    output logic [31:0]      target_3,
    output logic [31:0]      instructionPC_3,
    output logic             mispredict_3,
    output logic [31:0]      redirect_pc_3,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_JAL  = 3'd3;
    localparam logic [2:0] BR_JALR = 3'd4;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_valid_2, r_valid_3;
    logic [31:0]      r_pc_2, r_pc_3;
    logic             r_ptaken_2, r_ptaken_3;
    logic [31:0]      r_ptarget_2, r_ptarget_3;
    logic [CNT_W-1:0] r_branch_cnt, r_mispred_cnt;

    logic        w_br;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_mispredict;

    always_comb begin
        w_taken  = 1'b0;
        w_target = 32'd0;
        case (br_type_3)
            BR_BEQ: begin
                w_taken  = (rs1_3 == rs2_3);
                w_target = r_pc_3 + imm_3;
            end
            BR_BNE: begin
                w_taken  = (rs1_3 != rs2_3);
                w_target = r_pc_3 + imm_3;
            end
            BR_JAL: begin
                w_taken  = 1'b1;
                w_target = r_pc_3 + imm_3;
            end
            BR_JALR: begin
                w_taken  = 1'b1;
                w_target = (rs1_3 + imm_3) & ~32'd1;
            end
            default: begin
                w_taken  = 1'b0;
                w_target = 32'd0;
            end
        endcase
    end

    assign w_br      = r_valid_3 && (br_type_3 >= BR_BEQ) && (br_type_3 <= BR_JALR);
    assign w_next_pc = w_taken ? w_target : (r_pc_3 + 32'd4);

    // A predicted-taken non-branch also needs a redirect back to the fall-through PC.
    assign w_mispredict = (w_br && ((r_ptaken_3 != w_taken) ||
                                    (w_taken && (r_ptarget_3 != w_target)))) ||
                          (r_valid_3 && !w_br && r_ptaken_3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_2     <= 1'b0;
            r_pc_2        <= 32'd0;
            r_ptaken_2    <= 1'b0;
            r_ptarget_2   <= 32'd0;
            r_valid_3     <= 1'b0;
            r_pc_3        <= 32'd0;
            r_ptaken_3    <= 1'b0;
            r_ptarget_3   <= 32'd0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (!memory_stall) begin
            r_valid_2   <= fetch_valid_1 && !w_mispredict;
            r_pc_2      <= instructionPC_1;
            r_ptaken_2  <= pred_taken_1;
            r_ptarget_2 <= pred_target_1;
            r_valid_3   <= r_valid_2 && !w_mispredict;
            r_pc_3      <= r_pc_2;
            r_ptaken_3  <= r_ptaken_2;
            r_ptarget_3 <= r_ptarget_2;
            if (w_br && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
            end
        end
    end

    assign is_branchInst_3 = w_br;
    assign taken_3         = w_br && w_taken;
    assign prev_taken_3    = r_valid_3 && r_ptaken_3;
    assign target_3        = w_br ? w_target : 32'd0;
    assign instructionPC_3 = r_pc_3;
    assign mispredict_3    = w_mispredict;
    assign redirect_pc_3   = r_valid_3 ? w_next_pc : 32'd0;
    assign branch_cnt      = r_branch_cnt;
    assign mispred_cnt     = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expected stage-3 outputs,
// a negedge monitor pops and compares whenever a branch or mispredict is presented.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memory_stall;
    logic        fetch_valid_1;
    logic [31:0] instructionPC_1;
    logic        pred_taken_1;
    logic [31:0] pred_target_1;
    logic [2:0]  br_type_3;
    logic [31:0] rs1_3, rs2_3, imm_3;

    logic        is_branchInst_3, taken_3, prev_taken_3, mispredict_3;
    logic [31:0] target_3, instructionPC_3, redirect_pc_3;
    logic [15:0] branch_cnt, mispred_cnt;

    logic        s_is_branchInst_3, s_taken_3, s_prev_taken_3, s_mispredict_3;
    logic [31:0] s_target_3, s_instructionPC_3, s_redirect_pc_3;
    logic [1:0]  s_branch_cnt, s_mispred_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .memory_stall(memory_stall),
        .fetch_valid_1(fetch_valid_1), .instructionPC_1(instructionPC_1),
        .pred_taken_1(pred_taken_1), .pred_target_1(pred_target_1),
        .br_type_3(br_type_3), .rs1_3(rs1_3), .rs2_3(rs2_3), .imm_3(imm_3),
        .is_branchInst_3(is_branchInst_3), .taken_3(taken_3), .prev_taken_3(prev_taken_3),
        .target_3(target_3), .instructionPC_3(instructionPC_3), .mispredict_3(mispredict_3),
        .redirect_pc_3(redirect_pc_3), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .memory_stall(memory_stall),
        .fetch_valid_1(fetch_valid_1), .instructionPC_1(instructionPC_1),
        .pred_taken_1(pred_taken_1), .pred_target_1(pred_target_1),
        .br_type_3(br_type_3), .rs1_3(rs1_3), .rs2_3(rs2_3), .imm_3(imm_3),
        .is_branchInst_3(s_is_branchInst_3), .taken_3(s_taken_3), .prev_taken_3(s_prev_taken_3),
        .target_3(s_target_3), .instructionPC_3(s_instructionPC_3), .mispredict_3(s_mispredict_3),
        .redirect_pc_3(s_redirect_pc_3), .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    typedef struct packed {
        logic        isbr;
        logic        tk;
        logic        ptk;
        logic [31:0] tgt;
        logic [31:0] ipc;
        logic        mp;
        logic [31:0] rpc;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
        fetch_valid_1   = v;
        instructionPC_1 = pc;
        pred_taken_1    = pt;
        pred_target_1   = ptg;
    endtask

    task automatic ex(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        br_type_3 = bt;
        rs1_3     = a;
        rs2_3     = b;
        imm_3     = im;
    endtask

    // Fetch one instruction, then a bubble, so it sits in stage 3 on return.
    task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
        ex(3'd0, 32'd0, 32'd0, 32'd0);
        fetch(1'b1, pc, pt, ptg);
        tick();
        fetch(1'b0, 32'd0, 1'b0, 32'd0);
        tick();
    endtask

    task automatic expect_out(input logic isbr, input logic tk, input logic ptk,
                              input logic [31:0] tgt, input logic [31:0] ipc, input logic mp,
                              input logic [31:0] rpc, input logic [31:0] bc, input logic [31:0] mc);
        exp_t x;
        x.isbr = isbr; x.tk = tk; x.ptk = ptk; x.tgt = tgt; x.ipc = ipc;
        x.mp = mp; x.rpc = rpc; x.bcnt = bc; x.mcnt = mc;
        q.push_back(x);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (is_branchInst_3 === 1'b1 || mispredict_3 === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output pc=0x%h mispredict=%b required=no output",
                             instructionPC_3, mispredict_3);
                end else begin
                    e = q.pop_front();
                    chk("mon_is_branch",  {31'd0, is_branchInst_3}, {31'd0, e.isbr});
                    chk("mon_taken",      {31'd0, taken_3},         {31'd0, e.tk});
                    chk("mon_prev_taken", {31'd0, prev_taken_3},    {31'd0, e.ptk});
                    chk("mon_target",     target_3,                 e.tgt);
                    chk("mon_pc",         instructionPC_3,          e.ipc);
                    chk("mon_mispredict", {31'd0, mispredict_3},    {31'd0, e.mp});
                    chk("mon_redirect",   redirect_pc_3,            e.rpc);
                    chk("mon_branch_cnt", {16'd0, branch_cnt},      e.bcnt);
                    chk("mon_mispred_cnt",{16'd0, mispred_cnt},     e.mcnt);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        memory_stall = 1'b0;
        fetch(1'b0, 32'd0, 1'b0, 32'd0);
        ex(3'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_is_branch",   {31'd0, is_branchInst_3}, 32'd0);
        chk("rst_taken",       {31'd0, taken_3},         32'd0);
        chk("rst_prev_taken",  {31'd0, prev_taken_3},    32'd0);
        chk("rst_target",      target_3,                 32'd0);
        chk("rst_pc",          instructionPC_3,          32'd0);
        chk("rst_mispredict",  {31'd0, mispredict_3},    32'd0);
        chk("rst_redirect",    redirect_pc_3,            32'd0);
        chk("rst_branch_cnt",  {16'd0, branch_cnt},      32'd0);
        chk("rst_mispred_cnt", {16'd0, mispred_cnt},     32'd0);

        // Correct not-taken BEQ
        issue(32'h40, 1'b0, 32'h44);
        ex(3'd1, 32'd5, 32'd6, 32'h10);
        expect_out(1, 0, 0, 32'h50, 32'h40, 0, 32'h44, 0, 0);
        tick();
        ex(3'd0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("beq_branch_cnt",  {16'd0, branch_cnt},  32'd1);
        chk("beq_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);

        // Taken BNE predicted not-taken with younger valid instructions behind it
        fetch(1'b1, 32'h80, 1'b0, 32'h84);
        tick();
        fetch(1'b1, 32'h84, 1'b1, 32'h200);
        tick();
        fetch(1'b1, 32'h88, 1'b1, 32'h300);
        ex(3'd2, 32'd1, 32'd2, 32'h20);
        expect_out(1, 1, 0, 32'hA0, 32'h80, 1, 32'hA0, 1, 0);
        tick();
        fetch(1'b0, 32'd0, 1'b0, 32'd0);
        ex(3'd0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("flush_mispredict", {31'd0, mispredict_3}, 32'd0);
        chk("flush_prev_taken", {31'd0, prev_taken_3}, 32'd0);
        chk("flush_redirect",   redirect_pc_3,         32'd0);
        chk("bne_mispred_cnt",  {16'd0, mispred_cnt},  32'd1);
        chk("bne_branch_cnt",   {16'd0, branch_cnt},   32'd2);
        tick();
        #1;
        chk("discard_mispredict", {31'd0, mispredict_3}, 32'd0);
        chk("discard_prev_taken", {31'd0, prev_taken_3}, 32'd0);

        // JALR: bit 0 of rs1+imm cleared; correct then wrong predicted target
        issue(32'h200, 1'b1, 32'h110);
        ex(3'd4, 32'h101, 32'd0, 32'h10);
        expect_out(1, 1, 1, 32'h110, 32'h200, 0, 32'h110, 2, 1);
        tick();
        issue(32'h204, 1'b1, 32'h114);
        ex(3'd4, 32'h101, 32'd0, 32'h10);
        expect_out(1, 1, 1, 32'h110, 32'h204, 1, 32'h110, 3, 1);
        tick();

        // JAL with negative offset, then taken BEQ predicted correctly
        issue(32'h300, 1'b1, 32'h200);
        ex(3'd3, 32'd0, 32'd0, 32'hFFFF_FF00);
        expect_out(1, 1, 1, 32'h200, 32'h300, 0, 32'h200, 4, 2);
        tick();
        issue(32'h400, 1'b1, 32'h408);
        ex(3'd1, 32'd7, 32'd7, 32'd8);
        expect_out(1, 1, 1, 32'h408, 32'h400, 0, 32'h408, 5, 2);
        tick();
        ex(3'd0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("mid_branch_cnt", {16'd0, branch_cnt}, 32'd6);

        // Mispredict held in stage 3 by a 3-cycle stall; flush on the release edge
        fetch(1'b1, 32'h500, 1'b0, 32'h504);
        tick();
        fetch(1'b1, 32'h504, 1'b1, 32'h900);
        tick();
        fetch(1'b0, 32'd0, 1'b0, 32'd0);
        ex(3'd1, 32'd3, 32'd3, 32'h40);
        memory_stall = 1'b1;
        for (int i = 0; i < 4; i++) expect_out(1, 1, 0, 32'h540, 32'h500, 1, 32'h540, 6, 2);
        tick();
        tick();
        tick();
        memory_stall = 1'b0;
        fetch(1'b1, 32'h508, 1'b1, 32'hA00);
        tick();
        fetch(1'b0, 32'd0, 1'b0, 32'd0);
        ex(3'd0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("stall_flush_mispredict", {31'd0, mispredict_3}, 32'd0);
        chk("stall_flush_prev_taken", {31'd0, prev_taken_3}, 32'd0);
        chk("stall_mispred_cnt",      {16'd0, mispred_cnt},  32'd3);
        chk("stall_branch_cnt",       {16'd0, branch_cnt},   32'd7);
        tick();
        #1;
        chk("stall_discard_mispredict", {31'd0, mispredict_3}, 32'd0);

        // Non-branch predicted taken
        issue(32'h10, 1'b1, 32'h80);
        ex(3'd0, 32'd0, 32'd0, 32'd0);
        expect_out(0, 0, 1, 32'd0, 32'h10, 1, 32'h14, 7, 3);
        tick();
        #1;
        chk("nb_mispred_cnt",  {16'd0, mispred_cnt},  32'd4);
        chk("sat4_mispred_cnt", {30'd0, s_mispred_cnt}, 32'd3);
        chk("sat_branch_cnt",   {30'd0, s_branch_cnt},  32'd3);

        // Not-taken BNE predicted taken: fifth mispredict
        issue(32'h600, 1'b1, 32'h600);
        ex(3'd2, 32'd9, 32'd9, 32'd4);
        expect_out(1, 0, 1, 32'h604, 32'h600, 1, 32'h604, 7, 4);
        tick();
        ex(3'd0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("end_mispred_cnt",  {16'd0, mispred_cnt},   32'd5);
        chk("end_branch_cnt",   {16'd0, branch_cnt},    32'd8);
        chk("sat5_mispred_cnt", {30'd0, s_mispred_cnt}, 32'd3);

        // Reset during a stall clears the counters
        memory_stall = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        memory_stall = 1'b0;
        #1;
        chk("rst_stall_branch_cnt",  {16'd0, branch_cnt},  32'd0);
        chk("rst_stall_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);

        tick();
        tick();
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
